// File: rtl/bit_scanner.sv
// bit_scanner: streaming set-bit enumerator.
// A bitmap is accepted on the load port. The index of every set bit is then
// emitted on the output port, one per handshake, lowest-first or highest-first.
// All output data is derived combinationally from the pending bitmap, so it
// stays stable under back-pressure with no extra holding registers.
module bit_scanner #(
    parameter  int WIDTH     = 16,
    parameter  int MSB_FIRST = 0,
    localparam int IW        = $clog2(WIDTH),
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic [CW-1:0]    remaining,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_scan;
    logic             w_load_hs;
    logic             w_out_hs;
    logic             w_last;
    logic [IW-1:0]    w_lsb_idx;
    logic [IW-1:0]    w_msb_idx;
    logic [IW-1:0]    w_sel_idx;
    logic [CW-1:0]    w_popcount;

    assign w_scan = (r_state == SCAN);

    // Lowest set bit of pending: walk downward so the lowest set bit is
    // the last assignment and therefore wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        w_lsb_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lsb_idx = IW'(i);
            end
        end
    end

    // Highest set bit of pending: walk upward so the highest wins.
    always_comb begin
        w_msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_pending[i]) begin
                w_msb_idx = IW'(i);
            end
        end
    end

    // Population count of pending: the bits still to be emitted,
    // including the one currently presented.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcount = w_popcount + CW'(r_pending[i]);
        end
    end

    assign w_sel_idx = (MSB_FIRST != 0) ? w_msb_idx : w_lsb_idx;
    assign w_last    = w_scan && (w_popcount == CW'(1));

    // Output port: meaningful only in SCAN, forced to zero in IDLE.
    assign out_valid = w_scan;
    assign out_idx   = w_scan ? w_sel_idx  : '0;
    assign remaining = w_scan ? w_popcount : '0;
    assign out_last  = w_last;
    assign done      = r_done;

    // A new bitmap fits either when idle or when the final index of the
    // current one is being taken this cycle, which removes the gap cycle
    // between bitmaps. flush blocks loading outright.
    assign load_ready = !flush && (!w_scan || (out_ready && w_last));

    assign w_load_hs = load_valid && load_ready;
    assign w_out_hs  = w_scan && out_ready;

    // Next-state logic: consume the presented index, retire the bitmap on
    // its final index, take a new bitmap on a load, and let flush override
    // everything without raising done.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;

        if (w_out_hs) begin
            w_pending_nxt[w_sel_idx] = 1'b0;
            if (w_last) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
        end

        if (w_load_hs) begin
            if (load_bits != '0) begin
                w_pending_nxt = load_bits;
                w_state_nxt   = SCAN;
            end else begin
                // An empty bitmap is complete as soon as it is accepted.
                w_done_nxt = 1'b1;
            end
        end

        if (flush) begin
            w_pending_nxt = '0;
            w_state_nxt   = IDLE;
            w_done_nxt    = 1'b0;
        end
    end

    // State registers. pending is a plain register, not a memory, so it is
    // cleared on reset together with the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // same pre-edge values regardless of statement order.
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_bit_scanner.sv
// Directed bench for bit_scanner. Two 16-bit instances (LSB-first and
// MSB-first) share one set of inputs; two 256-bit instances share another.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
module tb_bit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    // 16-bit group
    logic        a_flush, a_load_valid, a_out_ready;
    logic [15:0] a_load_bits;
    logic        a0_load_ready, a0_out_valid, a0_out_last, a0_done;
    logic [3:0]  a0_out_idx;
    logic [4:0]  a0_remaining;
    logic        a1_load_ready, a1_out_valid, a1_out_last, a1_done;
    logic [3:0]  a1_out_idx;
    logic [4:0]  a1_remaining;

    // 256-bit group
    logic         b_flush, b_load_valid, b_out_ready;
    logic [255:0] b_load_bits;
    logic         b0_load_ready, b0_out_valid, b0_out_last, b0_done;
    logic [7:0]   b0_out_idx;
    logic [8:0]   b0_remaining;
    logic         b1_load_ready, b1_out_valid, b1_out_last, b1_done;
    logic [7:0]   b1_out_idx;
    logic [8:0]   b1_remaining;

    bit_scanner #(.WIDTH(16), .MSB_FIRST(0)) u_a0 (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .load_valid(a_load_valid), .load_ready(a0_load_ready), .load_bits(a_load_bits),
        .out_valid(a0_out_valid), .out_ready(a_out_ready), .out_idx(a0_out_idx),
        .out_last(a0_out_last), .remaining(a0_remaining), .done(a0_done)
    );

    bit_scanner #(.WIDTH(16), .MSB_FIRST(1)) u_a1 (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .load_valid(a_load_valid), .load_ready(a1_load_ready), .load_bits(a_load_bits),
        .out_valid(a1_out_valid), .out_ready(a_out_ready), .out_idx(a1_out_idx),
        .out_last(a1_out_last), .remaining(a1_remaining), .done(a1_done)
    );

    bit_scanner #(.WIDTH(256), .MSB_FIRST(0)) u_b0 (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .load_valid(b_load_valid), .load_ready(b0_load_ready), .load_bits(b_load_bits),
        .out_valid(b0_out_valid), .out_ready(b_out_ready), .out_idx(b0_out_idx),
        .out_last(b0_out_last), .remaining(b0_remaining), .done(b0_done)
    );

    bit_scanner #(.WIDTH(256), .MSB_FIRST(1)) u_b1 (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .load_valid(b_load_valid), .load_ready(b1_load_ready), .load_bits(b_load_bits),
        .out_valid(b1_out_valid), .out_ready(b_out_ready), .out_idx(b1_out_idx),
        .out_last(b1_out_last), .remaining(b1_remaining), .done(b1_done)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        a_flush      = 1'b0; a_load_valid = 1'b0; a_out_ready = 1'b0; a_load_bits = '0;
        b_flush      = 1'b0; b_load_valid = 1'b0; b_out_ready = 1'b0; b_load_bits = '0;
        #3;
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a0_out_valid); end
        total++; if (a0_out_idx !== 4'd0) begin bad++; $display("FAIL reset_out_idx: got %0d want 0", a0_out_idx); end
        total++; if (a0_out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", a0_out_last); end
        total++; if (a0_remaining !== 5'd0) begin bad++; $display("FAIL reset_remaining: got %0d want 0", a0_remaining); end
        total++; if (a0_load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", a0_load_ready); end
        total++; if (a0_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", a0_done); end
        total++; if (b1_remaining !== 9'd0) begin bad++; $display("FAIL reset_remaining_w256: got %0d want 0", b1_remaining); end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_lsb_basic();
        logic [3:0] exp_idx [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        a_out_ready  = 1'b1;
        a_load_valid = 1'b1;
        a_load_bits  = 16'h8421;
        @(negedge clk);
        total++; if (a0_load_ready !== 1'b1) begin bad++; $display("FAIL lsb_load_ready: got %b want 1", a0_load_ready); end
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL lsb_pre_valid: got %b want 0", a0_out_valid); end
        cyc();
        a_load_valid = 1'b0;
        a_load_bits  = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (a0_out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid[%0d]: got %b want 1", k, a0_out_valid); end
            total++; if (a0_out_idx !== exp_idx[k]) begin bad++; $display("FAIL lsb_idx[%0d]: got %0d want %0d", k, a0_out_idx, exp_idx[k]); end
            total++; if (a0_remaining !== 5'(4 - k)) begin bad++; $display("FAIL lsb_remaining[%0d]: got %0d want %0d", k, a0_remaining, 4 - k); end
            total++; if (a0_out_last !== (k == 3)) begin bad++; $display("FAIL lsb_last[%0d]: got %b want %b", k, a0_out_last, (k == 3)); end
            total++; if (a0_done !== 1'b0) begin bad++; $display("FAIL lsb_done_early[%0d]: got %b want 0", k, a0_done); end
            cyc();
        end
        @(negedge clk);
        total++; if (a0_done !== 1'b1) begin bad++; $display("FAIL lsb_done: got %b want 1", a0_done); end
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL lsb_post_valid: got %b want 0", a0_out_valid); end
        cyc();
        @(negedge clk);
        total++; if (a0_done !== 1'b0) begin bad++; $display("FAIL lsb_done_width: got %b want 0", a0_done); end
        cyc();
    endtask

    task automatic test_msb_backpressure();
        logic [3:0] exp_idx [3] = '{4'd8, 4'd7, 4'd0};
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0181;
        a_out_ready  = 1'b1;
        cyc();
        a_load_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a_out_ready = (c % 2 == 1);
            @(negedge clk);
            total++; if (a1_out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid[%0d]: got %b want 1", c, a1_out_valid); end
            total++; if (a1_out_idx !== exp_idx[c / 2]) begin bad++; $display("FAIL msb_idx[%0d]: got %0d want %0d", c, a1_out_idx, exp_idx[c / 2]); end
            total++; if (a1_remaining !== 5'(3 - c / 2)) begin bad++; $display("FAIL msb_remaining[%0d]: got %0d want %0d", c, a1_remaining, 3 - c / 2); end
            total++; if (a1_out_last !== (c / 2 == 2)) begin bad++; $display("FAIL msb_last[%0d]: got %b want %b", c, a1_out_last, (c / 2 == 2)); end
            cyc();
        end
        @(negedge clk);
        total++; if (a1_done !== 1'b1) begin bad++; $display("FAIL msb_done: got %b want 1", a1_done); end
        total++; if (a1_out_valid !== 1'b0) begin bad++; $display("FAIL msb_post_valid: got %b want 0", a1_out_valid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        a_out_ready  = 1'b1;
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0003;
        cyc();
        a_load_valid = 1'b0;
        @(negedge clk);
        total++; if (a0_out_idx !== 4'd0 || a0_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got idx=%0d valid=%b want idx=0 valid=1", a0_out_idx, a0_out_valid); end
        total++; if (a0_remaining !== 5'd2) begin bad++; $display("FAIL b2b_rem_first: got %0d want 2", a0_remaining); end
        cyc();
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0010;
        @(negedge clk);
        total++; if (a0_out_idx !== 4'd1 || a0_out_last !== 1'b1) begin bad++; $display("FAIL b2b_second: got idx=%0d last=%b want idx=1 last=1", a0_out_idx, a0_out_last); end
        total++; if (a0_load_ready !== 1'b1) begin bad++; $display("FAIL b2b_load_ready: got %b want 1", a0_load_ready); end
        cyc();
        a_load_valid = 1'b0;
        a_load_bits  = '0;
        @(negedge clk);
        total++; if (a0_out_valid !== 1'b1 || a0_out_idx !== 4'd4) begin bad++; $display("FAIL b2b_third: got idx=%0d valid=%b want idx=4 valid=1", a0_out_idx, a0_out_valid); end
        total++; if (a0_remaining !== 5'd1 || a0_out_last !== 1'b1) begin bad++; $display("FAIL b2b_third_last: got rem=%0d last=%b want rem=1 last=1", a0_remaining, a0_out_last); end
        total++; if (a0_done !== 1'b1) begin bad++; $display("FAIL b2b_done_first: got %b want 1", a0_done); end
        cyc();
        @(negedge clk);
        total++; if (a0_out_valid !== 1'b0 || a0_done !== 1'b1) begin bad++; $display("FAIL b2b_done_second: got valid=%b done=%b want valid=0 done=1", a0_out_valid, a0_done); end
        cyc();
        @(negedge clk);
        total++; if (a0_done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear: got %b want 0", a0_done); end
        // zero bitmap
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0000;
        total++; if (a0_load_ready !== 1'b1) begin bad++; $display("FAIL zero_load_ready: got %b want 1", a0_load_ready); end
        cyc();
        a_load_valid = 1'b0;
        @(negedge clk);
        total++; if (a0_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", a0_done); end
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid: got %b want 0", a0_out_valid); end
        total++; if (a0_load_ready !== 1'b1) begin bad++; $display("FAIL zero_load_ready_after: got %b want 1", a0_load_ready); end
        cyc();
        @(negedge clk);
        total++; if (a0_done !== 1'b0 || a0_out_valid !== 1'b0) begin bad++; $display("FAIL zero_after: got done=%b valid=%b want done=0 valid=0", a0_done, a0_out_valid); end
        cyc();
    endtask

    task automatic test_flush();
        a_out_ready  = 1'b1;
        a_load_valid = 1'b1;
        a_load_bits  = 16'hFFFF;
        cyc();
        a_load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (a0_out_idx !== 4'(k) || a0_remaining !== 5'(16 - k)) begin bad++; $display("FAIL flush_pre[%0d]: got idx=%0d rem=%0d want idx=%0d rem=%0d", k, a0_out_idx, a0_remaining, k, 16 - k); end
            cyc();
        end
        a_flush      = 1'b1;
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0001;
        @(negedge clk);
        total++; if (a0_load_ready !== 1'b0) begin bad++; $display("FAIL flush_load_ready: got %b want 0", a0_load_ready); end
        total++; if (a0_out_idx !== 4'd3 || a0_remaining !== 5'd13) begin bad++; $display("FAIL flush_cycle_out: got idx=%0d rem=%0d want idx=3 rem=13", a0_out_idx, a0_remaining); end
        cyc();
        a_flush      = 1'b0;
        a_load_valid = 1'b0;
        @(negedge clk);
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", a0_out_valid); end
        total++; if (a0_remaining !== 5'd0) begin bad++; $display("FAIL flush_remaining: got %0d want 0", a0_remaining); end
        total++; if (a0_done !== 1'b0 || a1_done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b/%b want 0/0", a0_done, a1_done); end
        cyc();
        @(negedge clk);
        total++; if (a0_done !== 1'b0 || a0_out_valid !== 1'b0) begin bad++; $display("FAIL flush_after: got done=%b valid=%b want done=0 valid=0", a0_done, a0_out_valid); end
        cyc();
    endtask

    task automatic test_reset_midscan();
        a_out_ready  = 1'b0;
        a_load_valid = 1'b1;
        a_load_bits  = 16'h00F0;
        cyc();
        a_load_valid = 1'b0;
        @(negedge clk);
        total++; if (a0_out_valid !== 1'b1 || a0_remaining !== 5'd4 || a0_out_idx !== 4'd4) begin bad++; $display("FAIL rst_pre: got valid=%b rem=%0d idx=%0d want 1/4/4", a0_out_valid, a0_remaining, a0_out_idx); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (a0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", a0_out_valid); end
        total++; if (a0_out_idx !== 4'd0 || a0_out_last !== 1'b0) begin bad++; $display("FAIL rst_mid_idx_last: got idx=%0d last=%b want 0/0", a0_out_idx, a0_out_last); end
        total++; if (a0_remaining !== 5'd0) begin bad++; $display("FAIL rst_mid_remaining: got %0d want 0", a0_remaining); end
        total++; if (a0_load_ready !== 1'b1 || a0_done !== 1'b0) begin bad++; $display("FAIL rst_mid_ready_done: got ready=%b done=%b want 1/0", a0_load_ready, a0_done); end
        cyc();
        #3 reset_n = 1'b1;
        @(negedge clk);
        total++; if (a0_done !== 1'b0 || a0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_release: got done=%b valid=%b want 0/0", a0_done, a0_out_valid); end
        cyc();
        a_out_ready  = 1'b1;
        a_load_valid = 1'b1;
        a_load_bits  = 16'h0004;
        cyc();
        a_load_valid = 1'b0;
        @(negedge clk);
        total++; if (a0_out_idx !== 4'd2 || a0_out_last !== 1'b1 || a0_remaining !== 5'd1) begin bad++; $display("FAIL rst_single: got idx=%0d last=%b rem=%0d want 2/1/1", a0_out_idx, a0_out_last, a0_remaining); end
        cyc();
        @(negedge clk);
        total++; if (a0_done !== 1'b1 || a0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_single_done: got done=%b valid=%b want 1/0", a0_done, a0_out_valid); end
        cyc();
    endtask

    task automatic test_full_width();
        b_load_bits      = '0;
        b_load_bits[0]   = 1'b1;
        b_load_bits[255] = 1'b1;
        b_load_valid     = 1'b1;
        b_out_ready      = 1'b1;
        cyc();
        b_load_valid = 1'b0;
        @(negedge clk);
        total++; if (b0_out_idx !== 8'd0 || b0_remaining !== 9'd2 || b0_out_last !== 1'b0) begin bad++; $display("FAIL w256_lsb_first: got idx=%0d rem=%0d last=%b want 0/2/0", b0_out_idx, b0_remaining, b0_out_last); end
        total++; if (b1_out_idx !== 8'd255 || b1_remaining !== 9'd2 || b1_out_last !== 1'b0) begin bad++; $display("FAIL w256_msb_first: got idx=%0d rem=%0d last=%b want 255/2/0", b1_out_idx, b1_remaining, b1_out_last); end
        cyc();
        @(negedge clk);
        total++; if (b0_out_idx !== 8'd255 || b0_remaining !== 9'd1 || b0_out_last !== 1'b1) begin bad++; $display("FAIL w256_lsb_second: got idx=%0d rem=%0d last=%b want 255/1/1", b0_out_idx, b0_remaining, b0_out_last); end
        total++; if (b1_out_idx !== 8'd0 || b1_remaining !== 9'd1 || b1_out_last !== 1'b1) begin bad++; $display("FAIL w256_msb_second: got idx=%0d rem=%0d last=%b want 0/1/1", b1_out_idx, b1_remaining, b1_out_last); end
        cyc();
        @(negedge clk);
        total++; if (b0_done !== 1'b1 || b1_done !== 1'b1 || b0_out_valid !== 1'b0 || b1_out_valid !== 1'b0) begin bad++; $display("FAIL w256_done: got done=%b/%b valid=%b/%b want 1/1 0/0", b0_done, b1_done, b0_out_valid, b1_out_valid); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_lsb_basic();
        test_msb_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midscan();
        test_full_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_scanner.md
# bit_scanner

Sequential set-bit enumerator: accepts a WIDTH-bit bitmap through a valid/ready load port and emits the index of every set bit, one per handshake, in LSB-first or MSB-first order. It generalises the combinational single-index encoders into a streaming, back-pressured engine. Typical consumers are request-mask walkers and event-flag servicing loops that must visit every active channel, not only the highest-priority one.

## Interface
- WIDTH, 16: bitmap width; legal range 2..256.
- MSB_FIRST, 0: 0 emits the lowest set index first; 1 emits the highest set index first.
- IW (localparam) = $clog2(WIDTH); CW (localparam) = $clog2(WIDTH+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  abandons the current bitmap; synchronous.
- load_valid  in  1  load_bits is valid.
- load_ready  out  1  block accepts a bitmap this cycle.
- load_bits  in  WIDTH  bitmap to enumerate.
- out_valid  out  1  out_idx holds a valid index.
- out_ready  in  1  consumer takes out_idx this cycle.
- out_idx  out  IW  index of the current set bit.
- out_last  out  1  out_idx is the final set bit of this bitmap.
- remaining  out  CW  popcount of the bits not yet emitted, including the current one.
- done  out  1  one-cycle pulse the cycle after the final index handshake.

## Operation
- State: FSM {IDLE, SCAN}; `pending` register of WIDTH bits; registered `done`.
- Reset values (reset_n low, asynchronous):
  - FSM = IDLE, pending = 0, done = 0.
  - Therefore out_valid = 0, out_idx = 0, out_last = 0, remaining = 0, load_ready = 1.
- load_ready = !flush && (IDLE || (SCAN && out_ready && out_last)).
- Load handshake (load_valid && load_ready):
  - Non-zero load_bits: pending <= load_bits; FSM -> SCAN.
  - Zero load_bits: accepted and discarded; FSM stays IDLE; done is pulsed next cycle; no index is emitted.
- Outputs in SCAN (all derived from `pending`):
  - out_valid = 1.
  - out_idx = lowest set bit of pending (MSB_FIRST=0) or highest set bit (MSB_FIRST=1).
  - out_last = (remaining == 1).
  - remaining = popcount(pending).
- Outputs in IDLE: out_valid = 0, out_idx = 0, out_last = 0, remaining = 0.
- Output handshake (out_valid && out_ready): clear bit out_idx of pending.
  - If out_last and no same-cycle load: FSM -> IDLE; done = 1 next cycle.
  - If out_last and a same-cycle load: the new bitmap is taken as in the load rules, and done = 1 next cycle.
- Stability: while out_valid && !out_ready, out_idx, out_last and remaining hold constant.
- flush (priority over everything except reset):
  - pending <= 0; FSM -> IDLE; done is not pulsed.
  - load_ready is 0 in the flush cycle, so no load is accepted.
  - An output handshake in the flush cycle is still counted as consumed by the consumer; the block discards the remaining bits.
- Bits of load_bits are sampled only on a load handshake. Changes to load_bits at other times have no effect.

## Timing
- Load latency: a bitmap accepted at edge N presents its first out_idx in the cycle after edge N (1 cycle).
- Throughput: one index per cycle while out_ready = 1. A bitmap with k set bits occupies SCAN for k cycles when there is no back-pressure.
- Back-to-back loads: a load can be accepted in the same cycle as the final handshake, so there is no idle bubble between bitmaps.
- Paths: load_ready depends combinationally on out_ready and flush. out_idx and remaining depend combinationally on `pending` only.
- done: registered; asserted exactly one cycle after the cycle of the final handshake, or after a zero-bitmap load.
- Reset asserted mid-SCAN: immediately returns to the reset values above; no done pulse.

## Test plan
- Basic LSB-first: WIDTH=16, MSB_FIRST=0, load 16'h8421, out_ready held at 1.
  - out_idx = 0, 5, 10, 15 on consecutive cycles.
  - out_last only on 15; remaining = 4, 3, 2, 1.
  - done one cycle after the final handshake.
- MSB-first with back-pressure: MSB_FIRST=1, load 16'h0181, out_ready toggling 1/0.
  - Order is 8, 7, 0.
  - out_idx and remaining hold on every out_ready = 0 cycle.
- Back-to-back and zero-bitmap loads:
  - 16'h0003 then 16'h0010 offered on the final handshake cycle: output 0, 1, 4 with no gap cycle.
  - Zero bitmap: load_ready stays 1, done pulses next cycle, out_valid never rises.
- Flush:
  - Load 16'hFFFF, consume 3 indices, assert flush with load_valid = 1 and load_bits = 16'h0001.
  - Required: load rejected; next cycle out_valid = 0 and remaining = 0; no done pulse.
- Reset mid-scan: assert reset_n low asynchronously between edges during SCAN.
  - All outputs go to their reset values immediately.
  - After release, 16'h0004 yields single index 2 with out_last = 1.
- Full width: WIDTH=256, bitmap with bits 0 and 255 set.
  - MSB_FIRST=0 gives 0, 255; MSB_FIRST=1 gives 255, 0.
  - remaining = 2 then 1.
